// File: rtl/lamp_fpu_round_pack.sv
// Rounding and packing back end for the lamp FPU: applies the selected IEEE rounding mode,
// resolves overflow to Inf or max-finite, packs {s, e, frac} and accumulates sticky flags.
module lamp_fpu_round_pack #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  s_i,
    input  logic [E_DW-1:0]       e_i,
    input  logic [F_DW+4:0]       f_i,
    input  logic                  isToRound_i,
    input  logic                  isOverflow_i,
    input  logic                  isUnderflow_i,
    input  logic [1:0]            rndMode_i,
    input  logic                  flagsClr_i,
    output logic [E_DW+F_DW:0]    result_o,
    output logic                  valid_o,
    output logic [2:0]            flags_o
);

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } rnd_t;

    rnd_t               mode;
    logic               lsb, grd, sticky, inexact, inc;
    logic [F_DW+1:0]    sum;
    logic [E_DW:0]      exp_r;
    logic [F_DW-1:0]    frac_n;
    logic [E_DW-1:0]    exp_n;
    logic               ovf_n, inf_n;
    logic [2:0]         op_flags_n;

    logic               s1_valid, s1_sign, s1_ovf, s1_inf;
    logic [E_DW-1:0]    s1_exp;
    logic [F_DW-1:0]    s1_frac;
    logic [2:0]         s1_flags;

    always_comb begin
        mode    = rnd_t'(rndMode_i);
        lsb     = f_i[3];
        grd     = f_i[2];
        sticky  = f_i[1] | f_i[0];
        inexact = isToRound_i & (grd | sticky);
        inc     = 1'b0;
        case (mode)
            RNE: inc = grd & (sticky | lsb);
            RTZ: inc = 1'b0;
            RDN: inc = s_i & (grd | sticky);
            RUP: inc = ~s_i & (grd | sticky);
            default: inc = 1'b0;
        endcase
        sum = {1'b0, f_i[F_DW+3:3]} + {{(F_DW+1){1'b0}}, inc};
        // A carry out renormalises; a denormal whose hidden bit becomes set turns into exponent 1.
        if (sum[F_DW+1]) begin
            frac_n = '0;
            exp_r  = {1'b0, e_i} + {{E_DW{1'b0}}, 1'b1};
        end else begin
            frac_n = sum[F_DW-1:0];
            exp_r  = (e_i == '0 && sum[F_DW]) ? {{E_DW{1'b0}}, 1'b1} : {1'b0, e_i};
        end
        exp_n      = exp_r[E_DW-1:0];
        ovf_n      = isOverflow_i | (exp_r >= {1'b0, {E_DW{1'b1}}});
        inf_n      = (mode == RNE) | (mode == RUP && !s_i) | (mode == RDN && s_i);
        op_flags_n = {ovf_n, isUnderflow_i | (exp_r == '0 && inexact), inexact | ovf_n};
        if (!isToRound_i) begin
            frac_n     = f_i[F_DW+4:5];
            exp_n      = e_i;
            ovf_n      = 1'b0;
            op_flags_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_ovf   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_flags <= '0;
        end else begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_sign  <= s_i;
                s1_exp   <= exp_n;
                s1_frac  <= frac_n;
                s1_ovf   <= ovf_n;
                s1_inf   <= inf_n;
                s1_flags <= op_flags_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_o <= '0;
            valid_o  <= 1'b0;
            flags_o  <= '0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                if (!s1_ovf)
                    result_o <= {s1_sign, s1_exp, s1_frac};
                else if (s1_inf)
                    result_o <= {s1_sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
                else
                    result_o <= {s1_sign, {{(E_DW-1){1'b1}}, 1'b0}, {F_DW{1'b1}}};
                flags_o <= (flagsClr_i ? 3'b000 : flags_o) | s1_flags;
            end else if (flagsClr_i) begin
                flags_o <= '0;
            end
        end
    end

endmodule

// File: doc/lamp_fpu_round_pack.md
LAMP_FPU_ROUND_PACK -- requirements
Module: lamp_fpu_round_pack

Interface
REQ-001 SHALL have parameter E_DW, default 8, exponent width (bfloat16).
REQ-002 SHALL have parameter F_DW, default 7, stored fraction width (bfloat16).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  operation present this cycle.
REQ-006 SHALL have port s_i  input  1  result sign from arithmetic stage.
REQ-007 SHALL have port e_i  input  E_DW  post-normalized biased exponent.
REQ-008 SHALL have port f_i  input  F_DW+5  {ovf, hidden, frac[F_DW-1:0], G, R, S} when isToRound_i=1; {frac[F_DW-1:0], 5'b0} when isToRound_i=0.
REQ-009 SHALL have port isToRound_i  input  1  0 = special (NaN/Inf) result, pass through.
REQ-010 SHALL have port isOverflow_i  input  1  overflow detected upstream.
REQ-011 SHALL have port isUnderflow_i  input  1  underflow detected upstream.
REQ-012 SHALL have port rndMode_i  input  2  00 RNE, 01 RTZ, 10 RDN, 11 RUP; sampled with valid_i.
REQ-013 SHALL have port flagsClr_i  input  1  clear accumulated flags.
REQ-014 SHALL have port result_o  output  1+E_DW+F_DW  packed {s, e, frac}.
REQ-015 SHALL have port valid_o  output  1  result_o valid.
REQ-016 SHALL have port flags_o  output  3  sticky {OF, UF, NX}.

Function
REQ-017 SHALL be a 2-stage pipeline: valid_i at edge N produces valid_o at edge N+2; throughput one op per cycle, no backpressure.
REQ-018 Stage 1 SHALL register the sign, the rounded mantissa, the exponent, the overflow decision, the per-op flags and the valid bit; stage 2 SHALL register the packed result, valid_o and flags_o.
REQ-019 L=f_i[3], G=f_i[2], S=f_i[1]|f_i[0]; inexact NX_op = isToRound_i & (G|S).
REQ-020 Increment: RNE G&(S|L); RTZ 0; RDN s_i&(G|S); RUP ~s_i&(G|S).
REQ-021 Sum = f_i[F_DW+3:3] + increment, (F_DW+2) bits; a carry out SHALL set frac=0 and exponent=e_i+1.
REQ-022 With e_i=0 and sum hidden bit=1 (denormal rounds up to normal), exponent SHALL become 1.
REQ-023 Overflow SHALL be isOverflow_i or a rounded exponent of 2^E_DW-1; the result SHALL then be Inf (e all-ones, frac 0) for RNE, for RUP when s=0, and for RDN when s=1, else max finite (e=2^E_DW-2, frac all-ones); OF_op=1 and NX_op=1.
REQ-024 UF_op SHALL be isUnderflow_i | (final exponent 0 & NX_op).
REQ-025 With isToRound_i=0, result SHALL be {s_i, e_i, f_i[F_DW+4:5]} unchanged, all per-op flags 0.
REQ-026 flags_o SHALL be flags_o | per-op flags at each edge where valid_o becomes/stays 1 for that op; with flagsClr_i=1 it SHALL load only the per-op flags of the op completing that edge (0 if none); new flags win over clear.
REQ-027 result_o SHALL hold its last value while valid_o=0; valid_i=0 bubbles SHALL produce valid_o=0 two edges later.

Reset
REQ-028 rst=1 SHALL asynchronously clear result_o, valid_o, flags_o and all stage valid/data registers to 0.
REQ-029 Operations in flight at reset SHALL be discarded; after release, valid_o SHALL stay 0 until 2 edges after the next valid_i.

Verification
REQ-030 RNE tie-to-odd: s=0, e=0x7F, f=0x40C (L=1,G=1,S=0) -> result 0x3F82, flags_o=001.
REQ-031 RNE tie-to-even: e=0x7F, f=0x404 (L=0,G=1) -> 0x3F80, NX; same with rndMode=RUP -> 0x3F81.
REQ-032 Carry: e=0x7F, f=0x7FE, RNE -> 0x4000; e=0xFE, f=0x7FC, RNE -> 0x7F80, flags 101; RTZ -> 0x7F7F, flags 001.
REQ-033 Passthrough: isToRound_i=0, s=0, e=0xFF, f=0x800 -> 0x7FC0, flags_o unchanged.
REQ-034 Flags: inexact op, then flagsClr_i=1 on completion edge of exact op -> flags_o=000; back-to-back ops yield valid_o on consecutive cycles in order.
REQ-035 Reset mid-op: valid_i at edge 0, rst pulsed between edges 0 and 1 -> valid_o=0 at edges 1-3, flags_o=000.
